// File: rtl/ir_queue_pkg.sv
// Shared types and constants for the instruction register/queue: assembler
// states, the queued instruction entry and the length-code encoding.
package ir_pkg;

  localparam int IR_DW      = 8;
  localparam int IR_MAX_LEN = 3;
  localparam int IR_DEPTH   = 4;
  localparam int IR_LEN_W   = $clog2(IR_MAX_LEN);
  localparam int IR_CNT_W   = $clog2(IR_DEPTH + 1);
  localparam int IR_ARG_W   = (IR_MAX_LEN - 1) * IR_DW;

  localparam logic [IR_LEN_W-1:0] LEN_1B = IR_LEN_W'(0);
  localparam logic [IR_LEN_W-1:0] LEN_2B = IR_LEN_W'(1);
  localparam logic [IR_LEN_W-1:0] LEN_3B = IR_LEN_W'(2);

  typedef enum logic {
    ASM_OP,
    ASM_ARG
  } asm_state_e;

  typedef struct packed {
    logic [IR_DW-1:0]    insn;
    logic [IR_ARG_W-1:0] data;
    logic [IR_LEN_W-1:0] len;
    logic                illegal;
  } ir_entry_t;

  // Length codes past the last operand slot cannot be assembled.
  function automatic logic len_legal(input logic [IR_LEN_W-1:0] len);
    return int'(len) <= IR_MAX_LEN - 1;
  endfunction

endpackage

// File: rtl/ir_queue_if.sv
// Fetch, opcode-decoder and decode-stage handshake bundle of the instruction
// queue. The queue uses the slave view; its environment uses the master view.
interface ir_queue_if
  import ir_pkg::*;
#(
  parameter int DW      = IR_DW,
  parameter int MAX_LEN = IR_MAX_LEN,
  parameter int DEPTH   = IR_DEPTH,
  parameter int LEN_W   = $clog2(MAX_LEN),
  parameter int CNT_W   = $clog2(DEPTH + 1)
) ();

  logic                    in_valid;
  logic [DW-1:0]           in_data;
  logic                    in_ready;

  logic [DW-1:0]           dec_op;
  logic [LEN_W-1:0]        dec_len;
  logic                    dec_ok;

  logic                    out_valid;
  logic                    out_ready;
  logic [DW-1:0]           out_insn;
  logic [(MAX_LEN-1)*DW-1:0] out_data;
  logic [LEN_W-1:0]        out_len;
  logic                    out_illegal;
  logic [CNT_W-1:0]        count;

  modport slave (
    input  in_valid, in_data, dec_len, dec_ok, out_ready,
    output in_ready, dec_op, out_valid, out_insn, out_data, out_len,
           out_illegal, count
  );

  modport master (
    output in_valid, in_data, dec_len, dec_ok, out_ready,
    input  in_ready, dec_op, out_valid, out_insn, out_data, out_len,
           out_illegal, count
  );

endinterface

// File: rtl/ir_queue_fifo.sv
// Synchronous FIFO of instruction entries with flush; the head is presented
// straight from storage and forced to zero while the FIFO is empty.
module ir_fifo
  import ir_pkg::*;
#(
  parameter int DEPTH = IR_DEPTH,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  ir_entry_t        wr_entry,
  output ir_entry_t        head,
  output logic             head_valid,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  ir_entry_t        mem_q [DEPTH];
  ir_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full       = (count_q == CNT_W'(DEPTH));
  assign head_valid = (count_q != '0);
  assign head       = head_valid ? mem_q[rd_ptr_q] : '0;
  assign count      = count_q;
  assign do_push    = push && !full;
  assign do_pop     = pop && head_valid;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wr_entry;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      // Simultaneous push and pop leaves occupancy unchanged.
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ir_queue.sv
// Instruction register and queue: assembles opcode plus operand bytes from the
// fetch stream and queues completed instructions for the decode stage.
module ir_queue
  import ir_pkg::*;
#(
  parameter int DW      = IR_DW,
  parameter int MAX_LEN = IR_MAX_LEN,
  parameter int DEPTH   = IR_DEPTH,
  parameter int LEN_W   = $clog2(MAX_LEN),
  parameter int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  ir_queue_if.slave   bus
);

  localparam int ARG_W = (MAX_LEN - 1) * DW;

  asm_state_e       state_q, state_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [DW-1:0]    op_q, op_d;
  logic [ARG_W-1:0] args_q, args_d;
  logic [ARG_W-1:0] args_w;

  logic             in_ready;
  logic             accept;
  logic             push;
  ir_entry_t        entry;
  ir_entry_t        head;
  logic             fifo_full;
  logic [CNT_W-1:0] fifo_count;

  // Gated by rst so fetch sees no ready while the queue is held in reset.
  assign in_ready     = rst && !fifo_full && !flush;
  assign accept       = bus.in_valid && in_ready;
  assign bus.in_ready = in_ready;
  assign bus.dec_op   = (state_q == ASM_OP) ? (rst ? bus.in_data : '0) : op_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    op_d    = op_q;
    args_d  = args_q;
    push    = 1'b0;
    entry   = '0;
    args_w  = args_q;
    // Operand slot 1 occupies the most significant byte of the operand field.
    for (int k = 1; k < MAX_LEN; k++) begin
      if (idx_q == LEN_W'(k)) begin
        args_w[ARG_W-k*DW +: DW] = bus.in_data;
      end
    end
    if (flush) begin
      state_d = ASM_OP;
      idx_d   = '0;
      args_d  = '0;
    end else if (accept) begin
      case (state_q)
        ASM_OP: begin
          entry.insn = bus.in_data;
          if (!bus.dec_ok || !len_legal(bus.dec_len)) begin
            push          = 1'b1;
            entry.illegal = 1'b1;
          end else if (bus.dec_len == LEN_1B) begin
            push = 1'b1;
          end else begin
            op_d    = bus.in_data;
            len_d   = bus.dec_len;
            idx_d   = LEN_W'(1);
            args_d  = '0;
            state_d = ASM_ARG;
          end
        end
        ASM_ARG: begin
          if (idx_q == len_q) begin
            push          = 1'b1;
            entry.insn    = op_q;
            entry.data    = args_w;
            entry.len     = len_q;
            entry.illegal = 1'b0;
            state_d       = ASM_OP;
            idx_d         = '0;
            args_d        = '0;
          end else begin
            idx_d  = idx_q + 1'b1;
            args_d = args_w;
          end
        end
        default: state_d = ASM_OP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ASM_OP;
      idx_q   <= '0;
      len_q   <= '0;
      op_q    <= '0;
      args_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      op_q    <= op_d;
      args_q  <= args_d;
    end
  end

  ir_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .push       (push),
    .pop        (bus.out_ready),
    .wr_entry   (entry),
    .head       (head),
    .head_valid (bus.out_valid),
    .full       (fifo_full),
    .count      (fifo_count)
  );

  assign bus.out_insn    = head.insn;
  assign bus.out_data    = head.data;
  assign bus.out_len     = head.len;
  assign bus.out_illegal = head.illegal;
  assign bus.count       = fifo_count;

endmodule

// File: tb/tb_ir_queue.sv
// Directed bench for ir_queue: a scoreboard queue of expected entries is
// filled by the stimulus and drained by an independent output monitor.
module tb_ir_queue;
  import ir_pkg::*;

  logic clk;
  logic rst;
  logic flush;
  int   checks;
  int   failures;
  ir_entry_t exp_q[$];

  ir_queue_if bus ();

  ir_queue dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Opcode table of the external length decoder.
  always_comb begin
    bus.dec_len = LEN_1B;
    bus.dec_ok  = 1'b1;
    case (bus.dec_op)
      8'h20, 8'h50: bus.dec_len = LEN_2B;
      8'h30:        bus.dec_len = LEN_3B;
      8'h40:        bus.dec_ok  = 1'b0;
      8'h70:        bus.dec_len = IR_LEN_W'(3);
      default:      bus.dec_len = LEN_1B;
    endcase
  end

  function automatic ir_entry_t mk(input logic [7:0] insn, input logic [15:0] data,
                                   input logic [1:0] len, input logic ill);
    ir_entry_t e;
    e.insn = insn; e.data = data; e.len = len; e.illegal = ill;
    return e;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && !flush && bus.out_valid && bus.out_ready) begin
      ir_entry_t got;
      ir_entry_t exp;
      got = mk(bus.out_insn, bus.out_data, bus.out_len, bus.out_illegal);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_entry: got insn=%0h data=%0h len=%0d ill=%0b expected none",
                 got.insn, got.data, got.len, got.illegal);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          failures++;
          $display("[TB] FAIL entry: got insn=%0h data=%0h len=%0d ill=%0b expected insn=%0h data=%0h len=%0d ill=%0b",
                   got.insn, got.data, got.len, got.illegal, exp.insn, exp.data, exp.len, exp.illegal);
        end
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic apply_stimulus(input logic [7:0] b);
    logic rdy;
    int   waited;
    waited       = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    do begin
      @(negedge clk);
      rdy = bus.in_ready;
      sync();
      waited++;
    end while (!rdy && waited < 50);
    if (!rdy) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout: got no in_ready expected byte %0h accepted", b);
    end
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
  endtask

  task automatic check_valid_next(input string name, input logic exp_valid);
    @(negedge clk);
    check_output(name, 32'(bus.out_valid), 32'(exp_valid));
    sync();
  endtask

  task automatic drain();
    int w;
    w = 0;
    bus.out_ready = 1'b1;
    while (exp_q.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    check_output("drain_left", 32'(exp_q.size()), 32'd0);
    check_output("drain_count", 32'(bus.count), 32'd0);
    sync();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    repeat (3) @(negedge clk);
    check_output("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check_output("rst_out_valid", 32'(bus.out_valid), 32'd0);
    sync();
    rst = 1'b1;
    @(negedge clk);
    check_output("rel_in_ready", 32'(bus.in_ready), 32'd1);
    check_output("rel_out_valid", 32'(bus.out_valid), 32'd0);
    check_output("rel_count", 32'(bus.count), 32'd0);
    check_output("rel_insn", 32'(bus.out_insn), 32'd0);
    check_output("rel_data", 32'(bus.out_data), 32'd0);
    check_output("rel_len_ill", 32'({bus.out_len, bus.out_illegal}), 32'd0);
    sync();

    // Mixed lengths, decode side always ready.
    bus.out_ready = 1'b1;
    exp_q.push_back(mk(8'h10, 16'h0000, 2'd0, 1'b0));
    apply_stimulus(8'h10);
    check_valid_next("lat_10", 1'b1);
    apply_stimulus(8'h20);
    check_valid_next("no_early_20", 1'b0);
    exp_q.push_back(mk(8'h20, 16'hAA00, 2'd1, 1'b0));
    apply_stimulus(8'hAA);
    check_valid_next("lat_20", 1'b1);
    apply_stimulus(8'h30);
    apply_stimulus(8'hBB);
    exp_q.push_back(mk(8'h30, 16'hBBCC, 2'd2, 1'b0));
    apply_stimulus(8'hCC);
    check_valid_next("lat_30", 1'b1);
    drain();

    // Fill to DEPTH with the decode side stalled.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(mk(8'h60 + 8'(i), 16'h0000, 2'd0, 1'b0));
      apply_stimulus(8'h60 + 8'(i));
    end
    @(negedge clk);
    check_output("full_count", 32'(bus.count), 32'd4);
    check_output("full_in_ready", 32'(bus.in_ready), 32'd0);
    sync();
    exp_q.push_back(mk(8'h64, 16'h0000, 2'd0, 1'b0));
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h64;
    @(negedge clk);
    check_output("held_in_ready", 32'(bus.in_ready), 32'd0);
    sync();
    @(negedge clk);
    check_output("held_count", 32'(bus.count), 32'd4);
    sync();
    bus.out_ready = 1'b1;
    sync();
    bus.out_ready = 1'b0;
    @(negedge clk);
    check_output("pop_count", 32'(bus.count), 32'd3);
    check_output("pop_in_ready", 32'(bus.in_ready), 32'd1);
    sync();
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    @(negedge clk);
    check_output("fifth_count", 32'(bus.count), 32'd4);
    sync();
    drain();

    // Illegal opcode, out-of-range length, then a normal 2-byte instruction.
    exp_q.push_back(mk(8'h40, 16'h0000, 2'd0, 1'b1));
    apply_stimulus(8'h40);
    exp_q.push_back(mk(8'h70, 16'h0000, 2'd0, 1'b1));
    apply_stimulus(8'h70);
    apply_stimulus(8'h50);
    exp_q.push_back(mk(8'h50, 16'h1100, 2'd1, 1'b0));
    apply_stimulus(8'h11);
    drain();

    // Flush discards a queued entry and a partial instruction.
    bus.out_ready = 1'b0;
    exp_q.push_back(mk(8'h10, 16'h0000, 2'd0, 1'b0));
    apply_stimulus(8'h10);
    apply_stimulus(8'h30);
    apply_stimulus(8'hBB);
    flush        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hEE;
    @(negedge clk);
    check_output("flush_in_ready", 32'(bus.in_ready), 32'd0);
    sync();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    exp_q.delete();
    @(negedge clk);
    check_output("flush_count", 32'(bus.count), 32'd0);
    check_output("flush_out_valid", 32'(bus.out_valid), 32'd0);
    sync();
    bus.out_ready = 1'b1;
    exp_q.push_back(mk(8'h10, 16'h0000, 2'd0, 1'b0));
    apply_stimulus(8'h10);
    drain();

    // Asynchronous reset mid-instruction with two entries queued.
    bus.out_ready = 1'b0;
    apply_stimulus(8'h10);
    apply_stimulus(8'h10);
    apply_stimulus(8'h30);
    @(negedge clk);
    check_output("pre_rst_count", 32'(bus.count), 32'd2);
    #2;
    rst = 1'b0;
    #1;
    check_output("arst_count", 32'(bus.count), 32'd0);
    check_output("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check_output("arst_in_ready", 32'(bus.in_ready), 32'd0);
    check_output("arst_insn", 32'(bus.out_insn), 32'd0);
    repeat (2) sync();
    rst = 1'b1;
    bus.out_ready = 1'b1;
    apply_stimulus(8'h20);
    exp_q.push_back(mk(8'h20, 16'h5A00, 2'd1, 1'b0));
    apply_stimulus(8'h5A);
    check_valid_next("lat_after_rst", 1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
